// File: rtl/seg_scan_scheduler_pkg.sv
// Shared types and constants for the seg_scan_scheduler 4-digit display controller.
package seg_scan_scheduler_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CAT_W  = 8;
  localparam int unsigned DATA_W = DIGITS * NIB_W;

  typedef enum logic [1:0] {
    ST_DIG0 = 2'd0,
    ST_DIG1 = 2'd1,
    ST_DIG2 = 2'd2,
    ST_DIG3 = 2'd3
  } scan_state_e;

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_id_e;

  localparam logic [CAT_W-1:0]  SEG_BLANK = 8'hFF;
  localparam logic [DIGITS-1:0] AN_OFF    = 4'b1111;

  // Active-low g..a patterns
  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  typedef struct packed {
    logic [DATA_W-1:0] digits;
    logic [DIGITS-1:0] dp;
  } frame_t;

endpackage

// File: rtl/seg_scan_scheduler_hex_decoder.sv
// Combinational hex nibble to active-low g..a segment pattern.
module seg_hex_decoder
  import seg_scan_scheduler_pkg::*;
(
  input  logic [NIB_W-1:0] hex_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK[SEG_W-1:0];
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK[SEG_W-1:0];
    endcase
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// 7-segment scan controller with frame-boundary round-robin arbitration of two requesters.
// Optional SEG_DIM_EN adds a bright[2:0] input and PWM dimming of the active anode.
module seg_scan_scheduler
  import seg_scan_scheduler_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD_CYC   = 500
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DIGITS-1:0] dp_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic [DIGITS-1:0] dp_b,
  output logic              gnt_b,
  input  logic              blank,
`ifdef SEG_DIM_EN
  input  logic [2:0]        bright,
`endif
  output logic [DIGITS-1:0] an,
  output logic [CAT_W-1:0]  cat,
  output logic              frame_sync
);

  localparam int unsigned      CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYC);

  scan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  frame_t            frame_q, frame_d;
  logic              valid_q, valid_d;
  rr_id_e            rr_last_q, rr_last_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [CAT_W-1:0]  cat_q, cat_d;

  logic              boundary_c, grant_a_c, grant_b_c, lit_c, dp_c;
  logic [NIB_W-1:0]  nib_c;
  logic [SEG_W-1:0]  seg_c;

`ifdef SEG_DIM_EN
  logic [2:0] pwm_q;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) pwm_q <= 3'd0;
    else       pwm_q <= pwm_q + 3'd1;
  end

  assign lit_c = ({1'b0, pwm_q} < ({1'b0, bright} + 4'd1));
`else
  assign lit_c = 1'b1;
`endif

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q   <= ST_DIG0;
      cnt_q     <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      rr_last_q <= RR_B;
      an_q      <= AN_OFF;
      cat_q     <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      rr_last_q <= rr_last_d;
      an_q      <= an_d;
      cat_q     <= cat_d;
    end
  end

  // Slot counter and digit sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      case (state_q)
        ST_DIG0: state_d = ST_DIG1;
        ST_DIG1: state_d = ST_DIG2;
        ST_DIG2: state_d = ST_DIG3;
        default: state_d = ST_DIG0;
      endcase
    end
  end

  // Grants are decided in the last cycle of the frame so the new frame starts clean
  assign boundary_c = (state_q == ST_DIG3) && (cnt_q == CNT_LAST);
  assign grant_a_c  = boundary_c && req_a && (!req_b || (rr_last_q == RR_B));
  assign grant_b_c  = boundary_c && req_b && (!req_a || (rr_last_q == RR_A));
  assign gnt_a      = grant_a_c;
  assign gnt_b      = grant_b_c;
  assign frame_sync = boundary_c;

  always_comb begin
    frame_d   = frame_q;
    valid_d   = valid_q;
    rr_last_d = rr_last_q;
    if (grant_a_c) begin
      frame_d   = '{digits: data_a, dp: dp_a};
      valid_d   = 1'b1;
      rr_last_d = RR_A;
    end else if (grant_b_c) begin
      frame_d   = '{digits: data_b, dp: dp_b};
      valid_d   = 1'b1;
      rr_last_d = RR_B;
    end
  end

  always_comb begin
    nib_c = frame_q.digits[3:0];
    dp_c  = frame_q.dp[0];
    case (state_q)
      ST_DIG1: begin nib_c = frame_q.digits[7:4];   dp_c = frame_q.dp[1]; end
      ST_DIG2: begin nib_c = frame_q.digits[11:8];  dp_c = frame_q.dp[2]; end
      ST_DIG3: begin nib_c = frame_q.digits[15:12]; dp_c = frame_q.dp[3]; end
      default: begin nib_c = frame_q.digits[3:0];   dp_c = frame_q.dp[0]; end
    endcase
  end

  seg_hex_decoder u_hex_decoder (
    .hex_i (nib_c),
    .seg_o (seg_c)
  );

  // Guard interval, blanking and an empty frame all keep the pins dark
  always_comb begin
    an_d  = AN_OFF;
    cat_d = SEG_BLANK;
    if (valid_q && !blank && lit_c && (cnt_q >= CNT_GUARD)) begin
      an_d  = ~(DIGITS'(1) << state_q);
      cat_d = {~dp_c, seg_c};
    end
  end

  assign an  = an_q;
  assign cat = cat_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Randomized scoreboard bench for seg_scan_scheduler (REFRESH_DIV=4, GUARD_CYC=1, 16-cycle frames).
module tb_seg_scan_scheduler;

  localparam int unsigned RD    = 4;
  localparam int unsigned GC    = 1;
  localparam int          FRAME = 16;

  logic        clk = 1'b0;
  logic        rest;
  logic        req_a, req_b, gnt_a, gnt_b, blank, frame_sync;
  logic [15:0] data_a, data_b;
  logic [3:0]  dp_a, dp_b, an;
  logic [7:0]  cat;
`ifdef SEG_DIM_EN
  logic [2:0]  bright;
`endif

  seg_scan_scheduler #(.REFRESH_DIV(RD), .GUARD_CYC(GC)) dut (
    .clk        (clk),
    .rest       (rest),
    .req_a      (req_a),
    .data_a     (data_a),
    .dp_a       (dp_a),
    .gnt_a      (gnt_a),
    .req_b      (req_b),
    .data_b     (data_b),
    .dp_b       (dp_b),
    .gnt_b      (gnt_b),
    .blank      (blank),
`ifdef SEG_DIM_EN
    .bright     (bright),
`endif
    .an         (an),
    .cat        (cat),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fs;
    logic [3:0] an;
    logic [7:0] cat;
  } cyc_exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        who;
  } gnt_exp_t;

  cyc_exp_t q_cyc[$];
  gnt_exp_t q_gnt[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  bit started = 0;

  // Reference model: frame position, displayed frame, round-robin memory, pending requests
  int          pos;
  bit          m_valid;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  bit          m_last_b;
  int          m_pwm;
  logic [11:0] prev_pins;
  bit          pa, pb;
  logic [6:0]  hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s cycle %0d: got nothing expected an entry", name, cyc);
  endtask

  function automatic logic [11:0] model_pins();
    int         slot;
    int         off;
    logic [3:0] nib;
    logic [3:0] a;
    slot = pos / int'(RD);
    off  = pos % int'(RD);
    if (blank || !m_valid || off < int'(GC)) return {4'hF, 8'hFF};
`ifdef SEG_DIM_EN
    if ((m_pwm % 8) >= int'(bright) + 1) return {4'hF, 8'hFF};
`endif
    nib     = m_dig[slot*4 +: 4];
    a       = 4'hF;
    a[slot] = 1'b0;
    return {a, ~m_dp[slot], hex_tbl[nib]};
  endfunction

  // Push this cycle's expectations, advance the model, move to the next cycle
  task automatic tick();
    cyc_exp_t e;
    gnt_exp_t g;
    bit       win_b;
    req_a = pa;
    req_b = pb;
    started = 1;
    if (!rest) begin
      e.fs = 1'b0; e.an = 4'hF; e.cat = 8'hFF;
      q_cyc.push_back(e);
      pos = 0; m_valid = 0; m_last_b = 1; m_pwm = 0;
      prev_pins = {4'hF, 8'hFF};
    end else begin
      e.fs = (pos == FRAME - 1);
      {e.an, e.cat} = prev_pins;
      q_cyc.push_back(e);
      prev_pins = model_pins();
      if (pos == FRAME - 1 && (pa || pb)) begin
        win_b = (pa && pb) ? !m_last_b : pb;
        g.cyc = cyc; g.who = win_b;
        q_gnt.push_back(g);
        m_last_b = win_b;
        m_valid  = 1;
        if (win_b) begin m_dig = data_b; m_dp = dp_b; pb = 0; end
        else       begin m_dig = data_a; m_dp = dp_a; pa = 0; end
      end
      pos = (pos + 1) % FRAME;
      m_pwm++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_req(input int odds);
    if (!pa && $urandom_range(0, odds) == 0) begin
      pa = 1; data_a = 16'($urandom); dp_a = 4'($urandom);
    end
    if (!pb && $urandom_range(0, odds) == 0) begin
      pb = 1; data_b = 16'($urandom); dp_b = 4'($urandom);
    end
  endtask

  always @(negedge clk) begin
    cyc_exp_t e;
    gnt_exp_t g;
    if (started) begin
      if (q_cyc.size() == 0) fail_now("cycle_queue");
      else begin
        e = q_cyc.pop_front();
        check("frame_sync", 32'(frame_sync), 32'(e.fs));
        check("an", 32'(an), 32'(e.an));
        check("cat", 32'(cat), 32'(e.cat));
      end
      if (gnt_a || gnt_b) begin
        check("gnt_onehot", 32'(gnt_a & gnt_b), 32'(0));
        if (q_gnt.size() == 0) fail_now("gnt_unexpected");
        else begin
          g = q_gnt.pop_front();
          check("gnt_cycle", 32'(cyc), g.cyc);
          check("gnt_who", 32'(gnt_b), 32'(g.who));
        end
      end
    end
  end

  initial begin
    rest = 1'b0; blank = 1'b0;
    pa = 0; pb = 0; req_a = 0; req_b = 0;
    data_a = '0; data_b = '0; dp_a = '0; dp_b = '0;
`ifdef SEG_DIM_EN
    bright = 3'd3;
`endif
    @(posedge clk);
    #1;
    repeat (3) tick();
    rest = 1'b1;

    // Idle after reset: dark display, frame_sync only
    repeat (40) tick();

    // Single requester A with a fixed frame
    pa = 1; data_a = 16'h12AF; dp_a = 4'b0001;
    for (int i = 0; i < 40 && pa; i++) tick();
    repeat (20) tick();

    // Both requesters held: alternating grants
    for (int i = 0; i < 96; i++) begin
      rand_req(0);
      tick();
    end

    // Blank asserted mid DIG2 with B pending
    for (int i = 0; i < FRAME && pos != 9; i++) tick();
    blank = 1'b1;
    if (!pb) begin pb = 1; data_b = 16'($urandom); dp_b = 4'($urandom); end
    repeat (24) tick();
    blank = 1'b0;
    repeat (8) tick();

    // Random traffic with random blanking
    for (int i = 0; i < 600; i++) begin
      rand_req(12);
      if ($urandom_range(0, 9) == 0) blank = ~blank;
      tick();
    end
    blank = 1'b0;
    repeat (48) tick();

    // Reset in the middle of a DIG1 slot while valid, then dark until new grant
    for (int i = 0; i < FRAME && pos != 5; i++) tick();
    rest = 1'b0;
    repeat (2) tick();
    rest = 1'b1;
    repeat (40) tick();
    pb = 1; data_b = 16'hC0DE; dp_b = 4'b1010;
    repeat (40) tick();

    started = 0;
    check("gnt_leftover", 32'(q_gnt.size()), 32'(0));
    check("cycle_leftover", 32'(q_cyc.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
